// File: rtl/tank_gfx_pkg.sv
// Shared definitions for the tank sprite graphics blocks: direction
// encodings, default sprite geometry, fetch FSM state codes and the tag
// that travels alongside each ROM read.
package tank_gfx_pkg;

  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  // Direction encodings, matching the order of the four ROM images
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Fetch sequencer states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Per-read tag carried through the ROM latency shift register
  typedef struct packed {
    logic             valid;
    logic             owner;
    logic [1:0]       dir;
    logic [COL_W-1:0] col;
  } pix_tag_t;

endpackage

// File: rtl/tank_sprite_fetch_arbiter_if.sv
// Bus bundle for tank_sprite_fetch_arbiter. The master side is the rest of
// the system (tank draw modules plus the ROM bank); the slave side is the
// arbiter. pix_opaque exists only when SPRITE_KEY_EN is defined.
//
// Handshake: a requester raises req[i] and holds it until it sees gnt[i]
// high for one cycle; the grant is taken combinationally in that same cycle
// and dir/row are latched then. Pixels are qualified by pix_valid only;
// there is no back-pressure on the pixel stream.
interface tank_sprite_fetch_arbiter_if #(
  parameter int RGB_W = 12
);
  import tank_gfx_pkg::*;

  logic [1:0]             req;
  logic [1:0]             dir0;
  logic [ROW_W-1:0]       row0;
  logic [1:0]             dir1;
  logic [ROW_W-1:0]       row1;
  logic [1:0]             gnt;
  logic [ROW_W+COL_W-1:0] rom_addr;
  logic [RGB_W-1:0]       rgb_up;
  logic [RGB_W-1:0]       rgb_down;
  logic [RGB_W-1:0]       rgb_right;
  logic [RGB_W-1:0]       rgb_left;
  logic [RGB_W-1:0]       pix_rgb;
  logic                   pix_valid;
  logic [COL_W-1:0]       pix_col;
  logic                   pix_owner;
  logic                   line_done;
  logic                   busy;
  logic [1:0]             state_dbg;
`ifdef SPRITE_KEY_EN
  logic                   pix_opaque;
`endif

  modport master (
    output req, dir0, row0, dir1, row1,
    output rgb_up, rgb_down, rgb_right, rgb_left,
    input  gnt, rom_addr, pix_rgb, pix_valid, pix_col, pix_owner,
    input  line_done, busy, state_dbg
`ifdef SPRITE_KEY_EN
    , input pix_opaque
`endif
  );

  modport slave (
    input  req, dir0, row0, dir1, row1,
    input  rgb_up, rgb_down, rgb_right, rgb_left,
    output gnt, rom_addr, pix_rgb, pix_valid, pix_col, pix_owner,
    output line_done, busy, state_dbg
`ifdef SPRITE_KEY_EN
    , output pix_opaque
`endif
  );

endinterface

// File: rtl/sprite_rr_arbiter.sv
// Two-way round-robin arbiter. Remembers which requester was served last
// and, when both ask, grants the other one. Comes out of reset preferring
// requester 0.
module sprite_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // One-hot grant: contention resolved by the last-served pointer
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
    else                gnt_o = req_i;
  end

  // Update the last-served pointer only when the grant is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      last_q <= 1'b1;
    else if (accept_i && |gnt_o)     last_q <= gnt_o[1];
  end

endmodule

// File: rtl/tank_sprite_fetch_arbiter.sv
// Shares the four-direction tank image ROM bank between the player (0) and
// opponent (1) draw modules. Grants one requester per line, walks all
// IMG_W columns of the latched row through the ROM, then returns a
// registered pixel stream selected by the latched direction.
// Optional feature macro: SPRITE_KEY_EN adds pix_opaque (colour != KEY_RGB).
module tank_sprite_fetch_arbiter #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int RGB_W   = 12,
  parameter int ROM_LAT = 1
`ifdef SPRITE_KEY_EN
  , parameter logic [RGB_W-1:0] KEY_RGB = '0
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tank_sprite_fetch_arbiter_if.slave  bus
);
  import tank_gfx_pkg::*;

  localparam int COL_BITS = $clog2(IMG_W);
  localparam int ROW_BITS = $clog2(IMG_H);
  localparam int DRN_W    = $clog2(ROM_LAT + 2);

  logic [1:0]          state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [1:0]          dir_q, dir_d;
  logic                owner_q, owner_d;
  logic [DRN_W-1:0]    drain_q, drain_d;

  logic [1:0]          arb_gnt;
  logic                arb_accept;

  pix_tag_t            issue;
  pix_tag_t            aligned;
  pix_tag_t            pipe_q [ROM_LAT];
  logic [RGB_W-1:0]    rgb_sel;

  logic [RGB_W-1:0]    pix_rgb_q;
  logic                pix_valid_q;
  logic [COL_W-1:0]    pix_col_q;
  logic                pix_owner_q;
  logic                line_done_q;

  // Grants are only taken while idle; the arbiter pointer moves with them
  assign arb_accept = (state_q == IDLE);

  sprite_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.req),
    .accept_i (arb_accept),
    .gnt_o    (arb_gnt)
  );

  // Next-state logic for the line sequencer (IDLE -> FETCH -> DRAIN)
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dir_d   = dir_q;
    owner_d = owner_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d = FETCH;
          col_d   = '0;
          owner_d = arb_gnt[1];
          row_d   = arb_gnt[1] ? bus.row1 : bus.row0;
          dir_d   = arb_gnt[1] ? bus.dir1 : bus.dir0;
        end
      end
      FETCH: begin
        // col stays at the last column so rom_addr holds outside FETCH
        if (col_q == COL_BITS'(IMG_W - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          col_d = col_q + COL_BITS'(1);
        end
      end
      DRAIN: begin
        // ROM_LAT+1 cycles: lets the last read reach the output register
        if (drain_q == DRN_W'(ROM_LAT)) state_d = IDLE;
        else                            drain_d = drain_q + DRN_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      dir_q   <= DIR_UP;
      owner_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dir_q   <= dir_d;
      owner_q <= owner_d;
      drain_q <= drain_d;
    end
  end

  // Tag of the read being issued this cycle
  always_comb begin
    issue.valid = (state_q == FETCH);
    issue.owner = owner_q;
    issue.dir   = dir_q;
    issue.col   = col_q;
  end

  // Delay the tag by ROM_LAT so it lines up with the returning ROM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign aligned = pipe_q[ROM_LAT-1];

  // Pick the direction image using the delayed direction
  always_comb begin
    rgb_sel = bus.rgb_up;
    case (aligned.dir)
      DIR_UP:    rgb_sel = bus.rgb_up;
      DIR_DOWN:  rgb_sel = bus.rgb_down;
      DIR_RIGHT: rgb_sel = bus.rgb_right;
      DIR_LEFT:  rgb_sel = bus.rgb_left;
      default:   rgb_sel = bus.rgb_up;
    endcase
  end

  // Output pixel register; fields are forced to 0 between valid pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_col_q   <= '0;
      pix_owner_q <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      pix_valid_q <= aligned.valid;
      pix_rgb_q   <= aligned.valid ? rgb_sel : '0;
      pix_col_q   <= aligned.valid ? aligned.col : '0;
      pix_owner_q <= aligned.valid & aligned.owner;
      line_done_q <= aligned.valid && (aligned.col == COL_W'(IMG_W - 1));
    end
  end

`ifdef SPRITE_KEY_EN
  logic pix_opaque_q;

  // Transparency flag registered alongside the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_opaque_q <= 1'b0;
    else        pix_opaque_q <= aligned.valid && (rgb_sel != KEY_RGB);
  end

  assign bus.pix_opaque = pix_opaque_q;
`endif

  assign bus.gnt       = arb_accept ? arb_gnt : 2'b00;
  assign bus.rom_addr  = {row_q, col_q};
  assign bus.pix_rgb   = pix_rgb_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_col   = pix_col_q;
  assign bus.pix_owner = pix_owner_q;
  assign bus.line_done = line_done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_tank_sprite_fetch_arbiter.sv
// Directed bench for tank_sprite_fetch_arbiter. A behavioural ROM bank with
// ROM_LAT cycles of latency returns a distinct pattern per direction.
// Optional feature macro: SPRITE_KEY_EN (enables the transparency test).
module tb_tank_sprite_fetch_arbiter;
  import tank_gfx_pkg::*;

  localparam int RGB_W   = 12;
  localparam int ROM_LAT = 1;
  localparam int P       = 66 + ROM_LAT;   // cycles from one gnt to the next

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic key_zero = 1'b0;

  always #5 clk = ~clk;

  tank_sprite_fetch_arbiter_if #(.RGB_W(RGB_W)) bus ();

  tank_sprite_fetch_arbiter #(
    .RGB_W   (RGB_W),
    .ROM_LAT (ROM_LAT)
`ifdef SPRITE_KEY_EN
    , .KEY_RGB (12'h000)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM bank model
  logic [11:0] addr_pipe [ROM_LAT];
  logic [11:0] ra;

  function automatic logic [11:0] rom_val(input logic [1:0] d, input logic [11:0] a);
    logic [11:0] v;
    case (d)
      DIR_UP:    v = a;
      DIR_DOWN:  v = ~a;
      DIR_RIGHT: v = a ^ 12'hA5A;
      default:   v = a + 12'h321;
    endcase
    if (key_zero && a[5:0] == 6'd10) v = 12'h000;
    return v;
  endfunction

  always @(posedge clk) begin
    addr_pipe[0] <= bus.rom_addr;
    for (int i = 1; i < ROM_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  assign ra            = addr_pipe[ROM_LAT-1];
  assign bus.rgb_up    = rom_val(DIR_UP, ra);
  assign bus.rgb_down  = rom_val(DIR_DOWN, ra);
  assign bus.rgb_right = rom_val(DIR_RIGHT, ra);
  assign bus.rgb_left  = rom_val(DIR_LEFT, ra);

  // Drivers
  task automatic drive_idle;
    bus.req  = 2'b00;
    bus.dir0 = 2'd0;
    bus.row0 = 6'd0;
    bus.dir1 = 2'd0;
    bus.row1 = 6'd0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    drive_idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 2'b00)       begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
    checks++; if (bus.rom_addr !== 12'h0)  begin errors++; $display("FAIL reset_rom_addr: got %h want 000", bus.rom_addr); end
    checks++; if (bus.pix_valid !== 1'b0)  begin errors++; $display("FAIL reset_pix_valid: got %b want 0", bus.pix_valid); end
    checks++; if (bus.pix_rgb !== 12'h0)   begin errors++; $display("FAIL reset_pix_rgb: got %h want 000", bus.pix_rgb); end
    checks++; if (bus.pix_col !== 6'd0)    begin errors++; $display("FAIL reset_pix_col: got %0d want 0", bus.pix_col); end
    checks++; if (bus.pix_owner !== 1'b0)  begin errors++; $display("FAIL reset_pix_owner: got %b want 0", bus.pix_owner); end
    checks++; if (bus.line_done !== 1'b0)  begin errors++; $display("FAIL reset_line_done: got %b want 0", bus.line_done); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Requester 0, right image, row 5; req dropped right after the grant
  task automatic test_single_line;
    int c;
    logic [11:0] ea;
    @(posedge clk);
    #1 bus.req = 2'b01; bus.dir0 = DIR_RIGHT; bus.row0 = 6'd5;
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_T: got %b want 0", bus.busy); end
    @(posedge clk);
    #1 bus.req = 2'b00;
    for (int n = 1; n <= P + 3; n++) begin
      @(negedge clk);
      c  = n - 2 - ROM_LAT;
      ea = (n <= IMG_W) ? (12'h140 + 12'(n - 1)) : 12'h17F;
      checks++; if (bus.rom_addr !== ea) begin errors++; $display("FAIL single_rom_addr n=%0d: got %h want %h", n, bus.rom_addr, ea); end
      checks++; if (bus.pix_valid !== (c >= 0 && c < 64)) begin errors++; $display("FAIL single_pix_valid n=%0d: got %b", n, bus.pix_valid); end
      if (c >= 0 && c < 64) begin
        checks++; if (bus.pix_rgb !== rom_val(DIR_RIGHT, 12'h140 + 12'(c))) begin errors++; $display("FAIL single_pix_rgb c=%0d: got %h want %h", c, bus.pix_rgb, rom_val(DIR_RIGHT, 12'h140 + 12'(c))); end
        checks++; if (bus.pix_col !== 6'(c)) begin errors++; $display("FAIL single_pix_col: got %0d want %0d", bus.pix_col, c); end
        checks++; if (bus.pix_owner !== 1'b0) begin errors++; $display("FAIL single_pix_owner: got %b want 0", bus.pix_owner); end
      end
      checks++; if (bus.line_done !== (c == 63)) begin errors++; $display("FAIL single_line_done n=%0d: got %b", n, bus.line_done); end
      checks++; if (bus.busy !== (n <= 65 + ROM_LAT)) begin errors++; $display("FAIL single_busy n=%0d: got %b", n, bus.busy); end
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL single_no_gnt n=%0d: got %b want 00", n, bus.gnt); end
      @(posedge clk);
    end
  endtask

  // Both requesters held: grants 01,10,01 with one idle cycle between lines
  task automatic test_back_to_back;
    int ph, li, c;
    logic own;
    logic [1:0] egnt;
    logic [11:0] ep;
    do_reset();
    @(posedge clk);
    #1 bus.req = 2'b11;
    bus.dir0 = DIR_DOWN; bus.row0 = 6'd2;
    bus.dir1 = DIR_LEFT; bus.row1 = 6'd7;
    for (int n = 0; n < 3 * P; n++) begin
      @(negedge clk);
      ph   = n % P;
      li   = n / P;
      own  = li[0];
      egnt = (ph == 0) ? (own ? 2'b10 : 2'b01) : 2'b00;
      c    = ph - 2 - ROM_LAT;
      checks++; if (bus.gnt !== egnt) begin errors++; $display("FAIL b2b_gnt n=%0d: got %b want %b", n, bus.gnt, egnt); end
      checks++; if (bus.busy !== (ph != 0)) begin errors++; $display("FAIL b2b_busy n=%0d: got %b", n, bus.busy); end
      checks++; if (bus.pix_valid !== (c >= 0 && c < 64)) begin errors++; $display("FAIL b2b_pix_valid n=%0d: got %b", n, bus.pix_valid); end
      if (c >= 0 && c < 64) begin
        ep = own ? rom_val(DIR_LEFT, {6'd7, 6'(c)}) : rom_val(DIR_DOWN, {6'd2, 6'(c)});
        checks++; if (bus.pix_owner !== own) begin errors++; $display("FAIL b2b_owner n=%0d: got %b want %b", n, bus.pix_owner, own); end
        checks++; if (bus.pix_rgb !== ep) begin errors++; $display("FAIL b2b_pix_rgb n=%0d: got %h want %h", n, bus.pix_rgb, ep); end
        checks++; if (bus.pix_col !== 6'(c)) begin errors++; $display("FAIL b2b_pix_col n=%0d: got %0d want %0d", n, bus.pix_col, c); end
      end
      checks++; if (bus.line_done !== (c == 63)) begin errors++; $display("FAIL b2b_line_done n=%0d: got %b", n, bus.line_done); end
      @(posedge clk);
    end
    #1 bus.req = 2'b00;
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL b2b_after_gnt: got %b want 00", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_after_busy: got %b want 0", bus.busy); end
  endtask

  // Requester 1, up image, row 9; dir1/row1 change mid-line and are ignored
  task automatic test_dir_change;
    int c, done_cnt;
    logic [11:0] ea;
    done_cnt = 0;
    @(posedge clk);
    #1 bus.req = 2'b10; bus.dir1 = DIR_UP; bus.row1 = 6'd9;
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL dir_gnt: got %b want 10", bus.gnt); end
    @(posedge clk);
    #1 bus.req = 2'b00;
    for (int n = 1; n <= P; n++) begin
      if (n == 20) begin bus.dir1 = DIR_LEFT; bus.row1 = 6'd1; end
      @(negedge clk);
      c = n - 2 - ROM_LAT;
      if (n <= IMG_W) begin
        ea = {6'd9, 6'(n - 1)};
        checks++; if (bus.rom_addr !== ea) begin errors++; $display("FAIL dir_rom_addr n=%0d: got %h want %h", n, bus.rom_addr, ea); end
      end
      if (c >= 0 && c < 64) begin
        checks++; if (bus.pix_rgb !== {6'd9, 6'(c)}) begin errors++; $display("FAIL dir_pix_rgb c=%0d: got %h want %h", c, bus.pix_rgb, {6'd9, 6'(c)}); end
        checks++; if (bus.pix_owner !== 1'b1) begin errors++; $display("FAIL dir_pix_owner: got %b want 1", bus.pix_owner); end
      end
      if (bus.line_done === 1'b1) done_cnt++;
      @(posedge clk);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL dir_line_done_count: got %0d want 1", done_cnt); end
  endtask

  // Reset asserted while column 30 is on rom_addr
  task automatic test_reset_midline;
    @(posedge clk);
    #1 bus.req = 2'b01; bus.dir0 = DIR_UP; bus.row0 = 6'd3;
    @(posedge clk);
    #1 bus.req = 2'b00;
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      checks++; if (bus.line_done !== 1'b0) begin errors++; $display("FAIL mid_line_done n=%0d: got %b want 0", n, bus.line_done); end
      if (n < 31) @(posedge clk);
    end
    checks++; if (bus.rom_addr !== {6'd3, 6'd30}) begin errors++; $display("FAIL mid_rom_addr: got %h want %h", bus.rom_addr, {6'd3, 6'd30}); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_pix_valid: got %b want 0", bus.pix_valid); end
    checks++; if (bus.pix_rgb !== 12'h0)  begin errors++; $display("FAIL mid_rst_pix_rgb: got %h want 000", bus.pix_rgb); end
    checks++; if (bus.rom_addr !== 12'h0) begin errors++; $display("FAIL mid_rst_rom_addr: got %h want 000", bus.rom_addr); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if (bus.line_done !== 1'b0) begin errors++; $display("FAIL mid_rst_line_done: got %b want 0", bus.line_done); end
    end
    @(posedge clk);
    #1 rst_n = 1'b1; bus.req = 2'b11;
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL mid_first_gnt: got %b want 01", bus.gnt); end
    @(posedge clk);
    #1 bus.req = 2'b00;
    repeat (P + 2) @(posedge clk);
  endtask

`ifdef SPRITE_KEY_EN
  // ROM returns the key colour at column 10 only
  task automatic test_key;
    int c;
    key_zero = 1'b1;
    @(posedge clk);
    #1 bus.req = 2'b01; bus.dir0 = DIR_RIGHT; bus.row0 = 6'd5;
    @(posedge clk);
    #1 bus.req = 2'b00;
    for (int n = 1; n <= P; n++) begin
      @(negedge clk);
      c = n - 2 - ROM_LAT;
      checks++;
      if (bus.pix_opaque !== ((c >= 0 && c < 64) && c != 10)) begin
        errors++; $display("FAIL key_opaque c=%0d: got %b", c, bus.pix_opaque);
      end
      @(posedge clk);
    end
    key_zero = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    drive_idle();
    test_reset();
    test_single_line();
    test_back_to_back();
    test_dir_change();
    test_reset_midline();
`ifdef SPRITE_KEY_EN
    test_key();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
